// File: rtl/fir_pkg.sv
// Shared types and default sizes for the time-multiplexed 3-tap FIR sequencer.
package fir_pkg;

  localparam int DW        = 8;
  localparam int TAPS      = 3;
  localparam int OW        = 16;
  localparam int TAP_IDX_W = $clog2(TAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in / result-out valid-ready streams of the FIR sequencer.
interface fir_tap_sequencer_if #(
  parameter int DW = 8,
  parameter int OW = 16
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;

  // Environment side: drives samples, accepts results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fir_mac_unit.sv
// The single shared multiply-accumulate: acc_out = acc_in + a*b, truncated to OW bits.
// Kept on its own so the multiplier implementation can be swapped without touching the sequencer.
module fir_mac_unit #(
  parameter int DW = 8,
  parameter int OW = 16
) (
  input  logic [OW-1:0] acc_in,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [OW-1:0] acc_out
);

  logic [2*DW-1:0] prod;

  // Unsigned product, then accumulate with natural wrap modulo 2^OW.
  always_comb begin
    prod    = a * b;
    acc_out = acc_in + OW'(prod);
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed 3-tap FIR controller: coefficient bank, delay line, and one
// shared MAC stepped across the taps, one tap per cycle.
//
//   state | meaning
//   IDLE  | waiting for a sample; coefficient writes accepted here only
//   MAC   | accumulating x[tap]*h[tap], one tap per cycle
//   OUT   | result presented, held until the sink takes it
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int DW   = fir_pkg::DW,
  parameter int TAPS = fir_pkg::TAPS,
  parameter int OW   = fir_pkg::OW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fir_tap_sequencer_if.slave       bus,
  input  logic                     cfg_we,
  input  logic [$clog2(TAPS)-1:0]  cfg_addr,
  input  logic [DW-1:0]            cfg_data,
  output logic                     cfg_err,
  output logic                     busy
);

  localparam int IW = $clog2(TAPS);
  localparam logic [IW-1:0] LAST_TAP = IW'(TAPS - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   tap;
  logic [DW-1:0]   h [TAPS];
  logic [DW-1:0]   x [TAPS];
  logic [OW-1:0]   acc;
  logic [OW-1:0]   mac_out;
  logic [OW-1:0]   out_data_r;
  logic            in_ready_int;
  logic            accept;

  // Ready is forced low while reset is held, even though the state already reads IDLE.
  assign in_ready_int  = (state == IDLE) && rst_n;
  assign accept        = bus.in_valid && in_ready_int;
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = out_data_r;
  assign busy          = (state != IDLE);

  fir_mac_unit #(.DW(DW), .OW(OW)) u_mac (
    .acc_in  (acc),
    .a       (x[tap]),
    .b       (h[tap]),
    .acc_out (mac_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept a sample, walk the taps, wait for the sink.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (tap == LAST_TAP) state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: delay line, accumulator, tap counter, result register, coefficient bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        h[i] <= '0;
        x[i] <= '0;
      end
      acc        <= '0;
      tap        <= '0;
      out_data_r <= '0;
      cfg_err    <= 1'b0;
    end else begin
      if (accept) begin
        x[0] <= bus.in_data;
        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        acc <= '0;
        tap <= '0;
      end
      if (state == MAC) begin
        acc <= mac_out;
        tap <= tap + IW'(1);
        // Result lives in its own register so it survives the acc clear on the next accept.
        if (tap == LAST_TAP) out_data_r <= mac_out;
      end
      // Writes in IDLE land on the same edge as a sample accept, so that sample sees them.
      if (cfg_we) begin
        if ((state == IDLE) && (cfg_addr <= LAST_TAP)) h[cfg_addr] <= cfg_data;
        else                                            cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: driver pushes hand-computed results into a
// queue, a separate monitor pops and compares on every output handshake.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  typedef struct {
    logic [15:0] val;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [TAP_IDX_W-1:0] cfg_addr = '0;
  logic [7:0]           cfg_data = '0;
  logic                 cfg_err;
  logic                 busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  fir_tap_sequencer_if #(.DW(8), .OW(16)) bus ();

  fir_tap_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one pop per output handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e.val));
          if (e.chk_lat) check("latency", 32'(cyc + 1 - e.acc_cyc), 32'd4);
        end
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = TAP_IDX_W'(addr);
    cfg_data = 8'(data);
    @(negedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  task automatic send(input int d, input int exp, input bit lat, input bit push);
    int n = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(d);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    e.val     = 16'(exp);
    e.acc_cyc = cyc + 1;
    e.chk_lat = lat;
    if (push) q.push_back(e);
    @(negedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Impulse response
    cfg_write(0, 1); cfg_write(1, 2); cfg_write(2, 3);
    send(1, 1, 0, 1); send(0, 2, 0, 1); send(0, 3, 0, 1);
    drain();

    // Convolution with latency; history from impulse has shifted out to zeros except x2
    send(1, 1, 1, 1); send(2, 4, 1, 1); send(3, 10, 1, 1);
    drain();
    check("out_data_hold", 32'(bus.out_data), 32'd10);

    // Wrap-around from a clean history
    do_reset();
    cfg_write(0, 255); cfg_write(1, 255); cfg_write(2, 255);
    send(255, 65025, 1, 1); send(255, 64514, 1, 1); send(255, 64003, 1, 1);
    drain();

    // Back-pressure
    do_reset();
    cfg_write(0, 1); cfg_write(1, 2); cfg_write(2, 3);
    bus.out_ready = 1'b0;
    send(4, 4, 0, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd7;
    begin
      int n = 0;
      while (!bus.out_valid && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
    end
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("bp_out_data_stable", 32'(bus.out_data), 32'd4);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(negedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_back_to_idle", 32'(bus.in_ready), 32'd1);
    send(7, 15, 0, 1);
    drain();

    // Config write during MAC is dropped; x = {7,4,0}, h = {1,2,3}
    check("cfg_err_clear", 32'(cfg_err), 32'd0);
    send(1, 27, 0, 1);
    cfg_write(1, 9);
    check("cfg_err_busy", 32'(cfg_err), 32'd1);
    send(2, 25, 0, 1);
    drain();

    // Reset mid-MAC, then out-of-range address in IDLE
    send(9, 0, 0, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    send(5, 0, 0, 1);
    drain();
    check("cfg_err_after_rst", 32'(cfg_err), 32'd0);
    cfg_write(3, 1);
    check("cfg_err_bad_addr", 32'(cfg_err), 32'd1);
    cfg_write(0, 2);
    send(5, 10, 0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
